register_file: RTL and testbench

//   General-purpose register file for the MIPS core: 32 x 32-bit registers, two

---
 rtl/register_file_if.sv | 23 ++
 rtl/register_file.sv | 38 +++
 tb/tb_register_file.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - decode/write-back bundle for the register file
interface register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] addr_1;
    logic [ADDR_WIDTH-1:0] addr_2;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  write;
    logic [DATA_WIDTH-1:0] data_1;
    logic [DATA_WIDTH-1:0] data_2;

    modport master (
        output addr_1, addr_2, wb_addr, wb_data, write,
        input  data_1, data_2
    );

    modport slave (
        input  addr_1, addr_2, wb_addr, wb_data, write,
        output data_1, data_2
    );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 MIPS GPR file, two async read ports, one write port
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                clk,
    input  logic                reset,
    register_file_if.slave      bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  wb_en;
    logic                  bypass_1;
    logic                  bypass_2;

    // r0 is never written, so it holds its reset value of zero forever
    assign wb_en = reset && bus.write && (bus.wb_addr != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Same-cycle write-through resolves the WB/ID hazard without a pipeline stall
    assign bypass_1 = wb_en && (bus.wb_addr == bus.addr_1);
    assign bypass_2 = wb_en && (bus.wb_addr == bus.addr_2);

    assign bus.data_1 = bypass_1              ? bus.wb_data :
                        (bus.addr_1 == '0)    ? '0          : regs[bus.addr_1];
    assign bus.data_2 = bypass_2              ? bus.wb_data :
                        (bus.addr_2 == '0)    ? '0          : regs[bus.addr_2];
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
`timescale 1ns/1ps
module tb_register_file;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;

    register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.write   = 1'b1;
        bus.wb_addr = a;
        bus.wb_data = d;
        @(negedge clk);
        bus.write   = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] exp_val;
        @(negedge clk);
        #2 reset = 1'b1;
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), ~32'(i));
        end
        bus.addr_1 = 5'd17;
        #1;
        exp_val = ~32'd17;
        checks++;
        if (bus.data_1 !== exp_val) begin
            fails++;
            $display("FAIL prefill_r17 got=%h exp=%h", bus.data_1, exp_val);
        end
        // Assert reset away from any edge and sweep all addresses before the next posedge
        @(negedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.addr_1 = 5'(i);
            bus.addr_2 = 5'(31 - i);
            #0.05;
            checks++;
            if (bus.data_1 !== 32'h0) begin
                fails++;
                $display("FAIL reset_data_1 addr=%0d got=%h exp=00000000", i, bus.data_1);
            end
            checks++;
            if (bus.data_2 !== 32'h0) begin
                fails++;
                $display("FAIL reset_data_2 addr=%0d got=%h exp=00000000", 31 - i, bus.data_2);
            end
        end
        do_write(5'd3, 32'h0BAD_F00D);
        bus.addr_1 = 5'd3;
        #1;
        checks++;
        if (bus.data_1 !== 32'h0) begin
            fails++;
            $display("FAIL write_during_reset got=%h exp=00000000", bus.data_1);
        end
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic test_write_read;
        do_write(5'd5, 32'hDEADBEEF);
        bus.addr_1 = 5'd5;
        bus.addr_2 = 5'd6;
        #1;
        checks++;
        if (bus.data_1 !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL write_r5 got=%h exp=deadbeef", bus.data_1);
        end
        checks++;
        if (bus.data_2 !== 32'h0) begin
            fails++;
            $display("FAIL read_r6 got=%h exp=00000000", bus.data_2);
        end
    endtask

    task automatic test_r0;
        @(negedge clk);
        bus.addr_1  = 5'd0;
        bus.addr_2  = 5'd0;
        bus.write   = 1'b1;
        bus.wb_addr = 5'd0;
        bus.wb_data = 32'hFFFFFFFF;
        #1;
        checks++;
        if (bus.data_1 !== 32'h0) begin
            fails++;
            $display("FAIL r0_before_edge got=%h exp=00000000", bus.data_1);
        end
        @(negedge clk);
        bus.write = 1'b0;
        #1;
        checks++;
        if (bus.data_1 !== 32'h0) begin
            fails++;
            $display("FAIL r0_after_edge_1 got=%h exp=00000000", bus.data_1);
        end
        checks++;
        if (bus.data_2 !== 32'h0) begin
            fails++;
            $display("FAIL r0_after_edge_2 got=%h exp=00000000", bus.data_2);
        end
    endtask

    task automatic test_bypass;
        @(negedge clk);
        bus.write   = 1'b1;
        bus.wb_addr = 5'd7;
        bus.wb_data = 32'h12345678;
        bus.addr_1  = 5'd7;
        bus.addr_2  = 5'd7;
        #1;
        checks++;
        if (bus.data_1 !== 32'h12345678) begin
            fails++;
            $display("FAIL bypass_1 got=%h exp=12345678", bus.data_1);
        end
        checks++;
        if (bus.data_2 !== 32'h12345678) begin
            fails++;
            $display("FAIL bypass_2 got=%h exp=12345678", bus.data_2);
        end
        @(negedge clk);
        bus.write = 1'b0;
        #1;
        checks++;
        if (bus.data_1 !== 32'h12345678) begin
            fails++;
            $display("FAIL stored_r7_1 got=%h exp=12345678", bus.data_1);
        end
        checks++;
        if (bus.data_2 !== 32'h12345678) begin
            fails++;
            $display("FAIL stored_r7_2 got=%h exp=12345678", bus.data_2);
        end
        // Independent ports: only port 2 matches the write-back index
        @(negedge clk);
        bus.write   = 1'b1;
        bus.wb_addr = 5'd8;
        bus.wb_data = 32'hCAFE0008;
        bus.addr_1  = 5'd7;
        bus.addr_2  = 5'd8;
        #1;
        checks++;
        if (bus.data_1 !== 32'h12345678) begin
            fails++;
            $display("FAIL bypass_indep_1 got=%h exp=12345678", bus.data_1);
        end
        checks++;
        if (bus.data_2 !== 32'hCAFE0008) begin
            fails++;
            $display("FAIL bypass_indep_2 got=%h exp=cafe0008", bus.data_2);
        end
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic test_write_disabled;
        @(negedge clk);
        bus.write   = 1'b0;
        bus.wb_addr = 5'd9;
        bus.wb_data = 32'hA5A5A5A5;
        bus.addr_1  = 5'd9;
        @(negedge clk);
        #1;
        checks++;
        if (bus.data_1 !== 32'h0) begin
            fails++;
            $display("FAIL write_disabled_r9 got=%h exp=00000000", bus.data_1);
        end
    endtask

    task automatic test_fill_pairs;
        logic [31:0] e1;
        logic [31:0] e2;
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), 32'(i) * 32'h01010101);
        end
        for (int i = 0; i < 32; i++) begin
            bus.addr_1 = 5'(i);
            bus.addr_2 = 5'(31 - i);
            #1;
            e1 = 32'(i) * 32'h01010101;
            e2 = 32'(31 - i) * 32'h01010101;
            checks++;
            if (bus.data_1 !== e1) begin
                fails++;
                $display("FAIL pair_data_1 addr=%0d got=%h exp=%h", i, bus.data_1, e1);
            end
            checks++;
            if (bus.data_2 !== e2) begin
                fails++;
                $display("FAIL pair_data_2 addr=%0d got=%h exp=%h", 31 - i, bus.data_2, e2);
            end
        end
        @(negedge clk);
        bus.addr_1 = 5'd31;
        bus.addr_2 = 5'd16;
        #2 reset = 1'b0;
        #0.1;
        checks++;
        if (bus.data_1 !== 32'h0) begin
            fails++;
            $display("FAIL midcycle_reset_1 got=%h exp=00000000", bus.data_1);
        end
        checks++;
        if (bus.data_2 !== 32'h0) begin
            fails++;
            $display("FAIL midcycle_reset_2 got=%h exp=00000000", bus.data_2);
        end
    endtask

    initial begin
        reset       = 1'b0;
        bus.addr_1  = '0;
        bus.addr_2  = '0;
        bus.wb_addr = '0;
        bus.wb_data = '0;
        bus.write   = 1'b0;
        #1;
        checks++;
        if (bus.data_1 !== 32'h0 || bus.data_2 !== 32'h0) begin
            fails++;
            $display("FAIL initial_reset got=%h/%h exp=00000000", bus.data_1, bus.data_2);
        end
        test_reset;
        test_write_read;
        test_r0;
        test_bypass;
        test_write_disabled;
        test_fill_pairs;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
